// File: rtl/k10_axil_timer.sv
`default_nettype none
// ============================================================================
// Module      : k10_axil_timer
// Description : RISC-V machine timer (mtime / mtimecmp) behind an AXI4-Lite
//               slave port. Only address bits [11:0] are decoded.
//               Register map (word offsets, addr[1:0] ignored):
//                 0x000 MTIME_LO     0x004 MTIME_HI
//                 0x008 MTIMECMP_LO  0x00C MTIMECMP_HI
//               Other offsets read as zero and ignore writes (OKAY response).
// Ports       : i_clk, i_rst          clock / async active-high reset
//               s_axi_*               AXI4-Lite slave (AW, W, B, AR, R)
//               o_timer_irq           level interrupt, mtime >= mtimecmp
//               o_mtime               live 64-bit mtime value
// Parameters  : PRESCALE              mtime ticks every PRESCALE clocks (>=1)
// Revision    : 1.0 - initial release
// ============================================================================
module k10_axil_timer #(
    parameter int PRESCALE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        o_timer_irq,
    output logic [63:0] o_mtime
);

    // A 1-bit counter is kept even for PRESCALE=1 so the vector is never empty.
    localparam int              c_PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(PRESCALE - 1);
    localparam logic [c_PW-1:0] c_PRESC_ONE = c_PW'(1);

    localparam logic [9:0] c_IDX_MTIME_LO = 10'd0;
    localparam logic [9:0] c_IDX_MTIME_HI = 10'd1;
    localparam logic [9:0] c_IDX_CMP_LO   = 10'd2;
    localparam logic [9:0] c_IDX_CMP_HI   = 10'd3;

    logic [63:0]     r_mtime;
    logic [63:0]     r_mtimecmp;
    logic [c_PW-1:0] r_presc;
    logic            r_irq;
    logic            r_bvalid;
    logic            r_rvalid;
    logic [31:0]     r_rdata;

    logic            w_wr_en;
    logic            w_rd_en;
    logic            w_tick;
    logic [9:0]      w_wr_idx;
    logic [9:0]      w_rd_idx;
    logic [63:0]     w_mtime_nxt;
    logic [63:0]     w_cmp_nxt;
    logic [31:0]     w_rd_data;
    logic            w_unused;

    // Byte-lane merge of write data into a 32-bit half.
    function automatic logic [31:0] f_merge(input logic [31:0] cur,
                                            input logic [31:0] wd,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? wd[8*i +: 8] : cur[8*i +: 8];
        end
        return res;
    endfunction

    // Both write channels handshake together in one cycle. Reset is folded in
    // so the ready outputs read low while reset is held.
    assign w_wr_en  = s_axi_awvalid & s_axi_wvalid & ~r_bvalid & ~i_rst;
    assign w_rd_en  = s_axi_arvalid & ~r_rvalid & ~i_rst;
    assign w_wr_idx = s_axi_awaddr[11:2];
    assign w_rd_idx = s_axi_araddr[11:2];
    assign w_tick   = (r_presc == c_PRESC_MAX);

    // A software write to either mtime half wins over the tick that cycle.
    always_comb begin
        w_mtime_nxt = r_mtime;
        if (w_wr_en && (w_wr_idx == c_IDX_MTIME_LO)) begin
            w_mtime_nxt = {r_mtime[63:32], f_merge(r_mtime[31:0], s_axi_wdata, s_axi_wstrb)};
        end else if (w_wr_en && (w_wr_idx == c_IDX_MTIME_HI)) begin
            w_mtime_nxt = {f_merge(r_mtime[63:32], s_axi_wdata, s_axi_wstrb), r_mtime[31:0]};
        end else if (w_tick) begin
            w_mtime_nxt = r_mtime + 64'd1;
        end
    end

    always_comb begin
        w_cmp_nxt = r_mtimecmp;
        if (w_wr_en && (w_wr_idx == c_IDX_CMP_LO)) begin
            w_cmp_nxt = {r_mtimecmp[63:32], f_merge(r_mtimecmp[31:0], s_axi_wdata, s_axi_wstrb)};
        end else if (w_wr_en && (w_wr_idx == c_IDX_CMP_HI)) begin
            w_cmp_nxt = {f_merge(r_mtimecmp[63:32], s_axi_wdata, s_axi_wstrb), r_mtimecmp[31:0]};
        end
    end

    always_comb begin
        w_rd_data = 32'd0;
        case (w_rd_idx)
            c_IDX_MTIME_LO: w_rd_data = r_mtime[31:0];
            c_IDX_MTIME_HI: w_rd_data = r_mtime[63:32];
            c_IDX_CMP_LO:   w_rd_data = r_mtimecmp[31:0];
            c_IDX_CMP_HI:   w_rd_data = r_mtimecmp[63:32];
            default:        w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_presc    <= '0;
            r_irq      <= 1'b0;
            r_bvalid   <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_cmp_nxt;
            // Free-running; software writes to mtime do not realign it.
            r_presc    <= w_tick ? '0 : (r_presc + c_PRESC_ONE);
            r_irq      <= (r_mtime >= r_mtimecmp);

            if (w_wr_en) begin
                r_bvalid <= 1'b1;
            end else if (s_axi_bready) begin
                r_bvalid <= 1'b0;
            end

            if (w_rd_en) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_axi_awready = w_wr_en;
    assign s_axi_wready  = w_wr_en;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_arready = ~r_rvalid & ~i_rst;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rvalid  = r_rvalid;
    assign o_timer_irq   = r_irq;
    assign o_mtime       = r_mtime;

    // Protection bits and undecoded address bits are intentionally ignored.
    assign w_unused = ^{s_axi_awprot, s_axi_arprot,
                        s_axi_awaddr[31:12], s_axi_awaddr[1:0],
                        s_axi_araddr[31:12], s_axi_araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_k10_axil_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_k10_axil_timer
// Description : Self-checking bench for k10_axil_timer. AXI responses are
//               checked by a monitor against expected values queued by the
//               stimulus; timer/irq values are checked at hand-derived times.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_k10_axil_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst4 = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        irq;
    logic [63:0] mtime;

    logic        awready4, wready4, bvalid4, arready4, rvalid4, irq4;
    logic [1:0]  bresp4, rresp4;
    logic [31:0] rdata4;
    logic [63:0] mtime4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_rd_q[$];
    logic [1:0]  exp_b_q[$];

    always #5 clk = ~clk;

    k10_axil_timer #(.PRESCALE(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_bresp(bresp),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_araddr(araddr),
        .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid),
        .s_axi_rready(rready), .o_timer_irq(irq), .o_mtime(mtime)
    );

    k10_axil_timer #(.PRESCALE(4)) dut4 (
        .i_clk(clk), .i_rst(rst4),
        .s_axi_awaddr(32'd0), .s_axi_awprot(3'b000), .s_axi_awvalid(1'b0),
        .s_axi_awready(awready4), .s_axi_wdata(32'd0), .s_axi_wstrb(4'b0000),
        .s_axi_wvalid(1'b0), .s_axi_wready(wready4), .s_axi_bresp(bresp4),
        .s_axi_bvalid(bvalid4), .s_axi_bready(1'b1), .s_axi_araddr(32'd0),
        .s_axi_arprot(3'b000), .s_axi_arvalid(1'b0), .s_axi_arready(arready4),
        .s_axi_rdata(rdata4), .s_axi_rresp(rresp4), .s_axi_rvalid(rvalid4),
        .s_axi_rready(1'b1), .o_timer_irq(irq4), .o_mtime(mtime4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each response is seen exactly once, on the negedge before the
    // posedge that completes its handshake.
    always @(negedge clk) begin
        if (rvalid && rready) begin
            if (exp_rd_q.size() == 0) begin
                check("unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                check("rdata", {32'd0, rdata}, {32'd0, exp_rd_q.pop_front()});
                check("rresp", {62'd0, rresp}, 64'd0);
            end
        end
        if (bvalid && bready) begin
            if (exp_b_q.size() == 0) begin
                check("unexpected_bvalid", 64'd1, 64'd0);
            end else begin
                check("bresp", {62'd0, bresp}, {62'd0, exp_b_q.pop_front()});
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        exp_b_q.push_back(2'b00);
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n == 50) check("write_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp);
        int n;
        exp_rd_q.push_back(exp);
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n == 50) check("read_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        // ---- reset release, PRESCALE=1 counting ----
        repeat (3) @(negedge clk);
        check("rst_mtime", mtime, 64'd0);
        check("rst_irq", {63'd0, irq}, 64'd0);
        check("rst_bvalid", {63'd0, bvalid}, 64'd0);
        check("rst_rvalid", {63'd0, rvalid}, 64'd0);
        check("rst_rdata", {32'd0, rdata}, 64'd0);
        check("rst_arready", {63'd0, arready}, 64'd0);
        rst = 1'b0;
        check("count0", mtime, 64'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("count", mtime, 64'(k));
        end
        axi_read(32'h4000_000C, 32'hFFFF_FFFF);
        axi_read(32'h4000_0008, 32'hFFFF_FFFF);
        check("irq_idle", {63'd0, irq}, 64'd0);

        // ---- compare match: irq one cycle after mtime reaches 50 ----
        axi_write(32'h4000_000C, 32'h0000_0000, 4'hF);
        axi_write(32'h4000_0000, 32'h0000_0000, 4'hF);
        axi_write(32'h4000_0008, 32'd50, 4'hF);
        n = 0;
        while (mtime != 64'd50 && n < 200) begin
            @(negedge clk); n++;
        end
        check("reach50", mtime, 64'd50);
        check("irq_before", {63'd0, irq}, 64'd0);
        @(negedge clk);
        check("irq_rise", {63'd0, irq}, 64'd1);
        repeat (5) @(negedge clk);
        check("irq_hold", {63'd0, irq}, 64'd1);
        axi_write(32'h4000_0008, 32'hFFFF_FFFF, 4'hF);
        check("irq_still", {63'd0, irq}, 64'd1);
        @(posedge clk); #1;
        check("irq_clear", {63'd0, irq}, 64'd0);

        // ---- carry from LO into HI ----
        axi_write(32'h4000_0004, 32'h0000_0000, 4'hF);
        axi_write(32'h4000_0000, 32'hFFFF_FFFF, 4'hF);
        check("mtime_wr", mtime, 64'h0000_0000_FFFF_FFFF);
        @(posedge clk); #1;
        check("mtime_carry", mtime, 64'h0000_0001_0000_0000);
        check("irq_equal", {63'd0, irq}, 64'd1);
        axi_read(32'h4000_0004, 32'h0000_0001);

        // ---- byte strobe, held bvalid, blocked second write ----
        bready = 1'b0;
        axi_write(32'h4000_0008, 32'h1234_5678, 4'b0010);
        exp_b_q.push_back(2'b00);
        awaddr = 32'h4000_0020; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bvalid_hold", {63'd0, bvalid}, 64'd1);
            check("aw_blocked", {63'd0, awready}, 64'd0);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(negedge clk);
        check("aw_blocked_hs", {63'd0, awready}, 64'd0);
        @(negedge clk); #1;
        check("aw_after_b", {63'd0, awready}, 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        axi_read(32'h4000_0008, 32'hFFFF_56FF);

        // ---- AW without W ----
        @(negedge clk);
        awaddr = 32'h4000_0010; wdata = 32'hAAAA_5555; wstrb = 4'hF;
        awvalid = 1'b1;
        exp_b_q.push_back(2'b00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("aw_no_w", {63'd0, awready}, 64'd0);
        end
        wvalid = 1'b1; #1;
        check("aw_w_ready", {62'd0, awready, wready}, 64'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        axi_read(32'h4000_0010, 32'h0000_0000);
        axi_read(32'h4000_000C, 32'h0000_0000);

        // ---- PRESCALE=4 ----
        @(negedge clk);
        rst4 = 1'b0;
        check("p4_start", mtime4, 64'd0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("p4_count", mtime4, 64'(k / 4));
        end

        // ---- async reset during an outstanding read ----
        repeat (3) @(negedge clk);
        rready = 1'b0;
        araddr = 32'h4000_0000; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("rvalid_wait", {63'd0, rvalid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rvalid", {63'd0, rvalid}, 64'd0);
        check("async_mtime", mtime, 64'd0);
        check("async_irq", {63'd0, irq}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rready = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_irq", {63'd0, irq}, 64'd0);
        check("post_rst_mtime", mtime, 64'd3);

        check("rd_q_empty", 64'(exp_rd_q.size()), 64'd0);
        check("b_q_empty", 64'(exp_b_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/k10_axil_timer.md
Name: k10_axil_timer

Overview:
- RISC-V machine timer (mtime/mtimecmp) peripheral with an AXI4-Lite slave port.
- Sits on the K10 peripheral bus at 0x4000_0000–0x4000_0FFF. Decodes only awaddr/araddr[11:0].
- Drives the core's timer interrupt and exports the free-running 64-bit mtime for the core's time CSRs.

Parameters:
- PRESCALE, 1, mtime increments once every PRESCALE clock cycles (≥1; 1 = every cycle).

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  asynchronous active-high reset
- s_axi_awaddr  in  32  write address
- s_axi_awprot  in  3  ignored
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte enables
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response, always 2'b00 OKAY
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  32  read address
- s_axi_arprot  in  3  ignored
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response, always 2'b00 OKAY
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- o_timer_irq  out  1  machine timer interrupt, level
- o_mtime  out  64  current mtime value

Behaviour:
Register map (offset = addr[11:0]; addr[1:0] ignored):
- 0x000 MTIME_LO, RW.
- 0x004 MTIME_HI, RW.
- 0x008 MTIMECMP_LO, RW.
- 0x00C MTIMECMP_HI, RW.
- All other offsets: reads return 0; writes are ignored but still complete with OKAY.

Reset values:
- mtime = 0.
- mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
- Prescale counter = 0.
- bvalid = 0, rvalid = 0, rdata = 0.
- awready = wready = arready = 0.
- o_timer_irq = 0.

Write channel:
- awready and wready are asserted together, combinationally, only when awvalid && wvalid && !bvalid.
- The write is therefore a single-cycle handshake on both channels.
- The register update occurs on that same clock edge; bvalid rises on the next cycle.
- bvalid holds until bready; the next write is accepted no earlier than the cycle after the bvalid/bready handshake.
- wstrb[i] enables byte i of the addressed 32-bit half; unstrobed bytes keep their current value.

Read channel:
- arready = !rvalid.
- On the arvalid && arready handshake, rdata is captured from the registers as they are at that edge, and rvalid rises on the next cycle.
- rdata/rvalid hold until rready.
- Read latency is 1 cycle.
- Reads and writes are fully independent and may complete in the same cycle.

mtime counting:
- Increments by 1 (64-bit, wraps 2^64-1 → 0) each time the prescale counter reaches PRESCALE-1; the counter then resets to 0.
- A software write to MTIME_LO or MTIME_HI takes precedence over the increment in that cycle.
- On a write cycle, mtime takes the merged value: written bytes are replaced, the rest of the current value is kept, and there is no increment.
- The prescale counter is not reset by the write.

Interrupt:
- o_timer_irq = (mtime >= mtimecmp), unsigned 64-bit compare, registered.
- Updates one cycle after mtime or mtimecmp changes.
- It is a level output: it stays high until software raises mtimecmp above mtime or lowers mtime.
- With reset mtimecmp the IRQ never fires until mtimecmp is programmed.

Other rules:
- o_mtime is the mtime register directly, with no extra delay.
- Halves are independent: software writing a 64-bit mtimecmp should write HI = all-ones first, then LO, then HI. This is not enforced.
- Reset asserted mid-transaction drops bvalid/rvalid immediately; the outstanding transaction is lost.

Test Plan:
- Reset release, PRESCALE=1 -> o_mtime counts 0,1,2,… each cycle; o_timer_irq=0; read 0x00C returns 0xFFFFFFFF.
- Write MTIMECMP_HI=0, then MTIMECMP_LO=50 -> o_timer_irq rises one cycle after mtime reaches 50 and stays high; write MTIMECMP_LO=0xFFFFFFFF -> irq clears next cycle.
- Write MTIME_LO=0xFFFFFFFF with wstrb=4'b1111 while MTIME_HI=0 -> next cycle o_mtime=0x0000_0000_FFFF_FFFF, then 0x0000_0001_0000_0000 (carry into HI).
- Write 0x12345678 to MTIMECMP_LO with wstrb=4'b0010 from all-ones -> readback 0xFFFF56FF; bresp=OKAY, bvalid held while bready=0 for 3 cycles, no second write accepted meanwhile.
- AW valid without W valid for 5 cycles -> awready stays 0; W arrives -> both handshake the same cycle; read of offset 0x010 returns 0 with rresp=OKAY.
- PRESCALE=4 -> mtime increments every 4th cycle; reset asserted asynchronously mid-read -> rvalid=0 and mtime=0 immediately.
